// File: rtl/sevenseg_pkg.sv
// ============================================================================
// sevenseg_pkg : shared constants and the segment decoder for the 7-seg monitor
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sevenseg_pkg;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIG0 = 4'b0111;
  localparam logic [3:0] AN_DIG1 = 4'b1011;
  localparam logic [3:0] AN_DIG2 = 4'b1101;
  localparam logic [3:0] AN_DIG3 = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [3:0] DIG_BLANK = 4'd15;
  localparam logic [3:0] DIG_ERR   = 4'd14;

  typedef enum logic [1:0] {
    KIND_SLOT = 2'd0,
    KIND_OFF  = 2'd1,
    KIND_BAD  = 2'd2
  } an_kind_e;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] code;
    case (s)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = DIG_BLANK;
      default:   code = DIG_ERR;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_stable_filter.sv
// ============================================================================
// sevenseg_stable_filter : 2-flop synchronizer, stability counter, one-shot sample
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sevenseg_stable_filter #(
  parameter int WIDTH         = 12,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             strobe
);

  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_STROBE_AT = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sample;
  logic [CNT_W-1:0] r_cnt;
  logic             r_strobe;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_changed;

  assign w_changed = (r_sync2 != r_prev);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed)
      w_cnt_next = '0;
    else if (r_cnt != C_CNT_MAX)
      w_cnt_next = r_cnt + 1'b1;
  end

  // Sync/prev start at the idle bus level so an idle bus after reset is not a change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_prev   <= '1;
      r_sample <= '1;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_sync1  <= din;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_cnt    <= w_cnt_next;
      r_strobe <= (w_cnt_next == C_STROBE_AT) && (w_changed || (r_cnt != C_STROBE_AT));
      if (w_cnt_next == C_STROBE_AT)
        r_sample <= r_sync2;
    end
  end

  assign dout   = r_sample;
  assign strobe = r_strobe;

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_decoder.sv
// ============================================================================
// sevenseg_scan_decoder : decodes a multiplexed active-low 7-seg bus into frames
// Option: SEVENSEG_DEC_ERRCNT_EN adds a saturating err_count output.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] dp_mask,
  output logic       frame_valid,
  output logic       display_off,
`ifdef SEVENSEG_DEC_ERRCNT_EN
  output logic [7:0] err_count,
`endif
  output logic       err_anode,
  output logic       err_seg
);

  logic [11:0] w_sample;
  logic        w_strobe;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_dp;
  logic [3:0]  w_code;
  an_kind_e    w_kind;
  logic [1:0]  w_slot;
  logic [3:0]  w_seen_next;
  logic [3:0]  w_dig_next [4];
  logic [3:0]  w_dpm_next;
  logic [3:0]  r_shadow [4];
  logic [3:0]  r_shadow_dp;
  logic [3:0]  r_seen;

  sevenseg_stable_filter #(
    .WIDTH         (12),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({an, seg, dp}),
    .dout   (w_sample),
    .strobe (w_strobe)
  );

  assign {w_an, w_seg, w_dp} = w_sample;
  assign w_code      = seg_decode(w_seg);
  assign w_seen_next = r_seen | (4'b0001 << w_slot);

  always_comb begin
    w_kind = KIND_BAD;
    w_slot = 2'd0;
    case (w_an)
      AN_DIG0: begin w_kind = KIND_SLOT; w_slot = 2'd0; end
      AN_DIG1: begin w_kind = KIND_SLOT; w_slot = 2'd1; end
      AN_DIG2: begin w_kind = KIND_SLOT; w_slot = 2'd2; end
      AN_DIG3: begin w_kind = KIND_SLOT; w_slot = 2'd3; end
      AN_OFF:  w_kind = KIND_OFF;
      default: w_kind = KIND_BAD;
    endcase
  end

  // Frame contents as they will be once the current sample lands in its shadow
  always_comb begin
    w_dpm_next         = r_shadow_dp;
    w_dpm_next[w_slot] = ~w_dp;
    for (int i = 0; i < 4; i++)
      w_dig_next[i] = (w_slot == 2'(i)) ? w_code : r_shadow[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_0     <= DIG_BLANK;
      digit_1     <= DIG_BLANK;
      digit_2     <= DIG_BLANK;
      digit_3     <= DIG_BLANK;
      dp_mask     <= 4'b0000;
      frame_valid <= 1'b0;
      display_off <= 1'b0;
      err_anode   <= 1'b0;
      err_seg     <= 1'b0;
      r_seen      <= 4'b0000;
      r_shadow_dp <= 4'b0000;
      for (int i = 0; i < 4; i++)
        r_shadow[i] <= DIG_BLANK;
    end else begin
      frame_valid <= 1'b0;
      err_anode   <= 1'b0;
      err_seg     <= 1'b0;
      if (w_strobe) begin
        case (w_kind)
          KIND_SLOT: begin
            r_shadow[w_slot]    <= w_code;
            r_shadow_dp[w_slot] <= ~w_dp;
            display_off         <= 1'b0;
            err_seg             <= (w_code == DIG_ERR);
            if (w_seen_next == 4'b1111) begin
              digit_0     <= w_dig_next[0];
              digit_1     <= w_dig_next[1];
              digit_2     <= w_dig_next[2];
              digit_3     <= w_dig_next[3];
              dp_mask     <= w_dpm_next;
              frame_valid <= 1'b1;
              r_seen      <= 4'b0000;
            end else begin
              r_seen <= w_seen_next;
            end
          end
          KIND_OFF: begin
            display_off <= 1'b1;
            r_seen      <= 4'b0000;
          end
          default: err_anode <= 1'b1;
        endcase
      end
    end
  end

`ifdef SEVENSEG_DEC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if ((err_anode || err_seg) && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan_decoder.sv
// ============================================================================
// tb_sevenseg_scan_decoder : directed table, latency/reset sequences, random scans
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sevenseg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic       dp = 1'b1;
  logic [3:0] digit_0, digit_1, digit_2, digit_3, dp_mask;
  logic       frame_valid, display_off, err_anode, err_seg;
`ifdef SEVENSEG_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  sevenseg_scan_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .digit_0     (digit_0),
    .digit_1     (digit_1),
    .digit_2     (digit_2),
    .digit_3     (digit_3),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .display_off (display_off),
`ifdef SEVENSEG_DEC_ERRCNT_EN
    .err_count   (err_count),
`endif
    .err_anode   (err_anode),
    .err_seg     (err_seg)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int fv_cnt = 0, ea_cnt = 0, es_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (err_anode)   ea_cnt <= ea_cnt + 1;
    if (err_seg)     es_cnt <= es_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    an = 4'hF; seg = 7'h7F; dp = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int dig_word();
    return int'({digit_3, digit_2, digit_1, digit_0});
  endfunction

  // Reference model: works per held input segment, not per clock
  logic [6:0] pat [11];
  int         m_sh [4];
  logic [3:0] m_sdp, m_seen, m_dpm;
  int         m_dig [4];
  logic       m_off;
  int         m_fv, m_ea, m_es, m_ec;
  logic [11:0] m_prev;

  function automatic int ref_decode(input logic [6:0] s);
    for (int i = 0; i < 11; i++)
      if (s == pat[i]) return (i < 10) ? i : 15;
    return 14;
  endfunction

  function automatic int ref_slot(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (a == ~(4'b1000 >> i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_sh[i] = 15; m_dig[i] = 15; end
    m_sdp = 0; m_seen = 0; m_dpm = 0; m_off = 0;
    m_fv = 0; m_ea = 0; m_es = 0; m_ec = 0;
    m_prev = 12'hFFF;
  endtask

  task automatic model_segment(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
    int sl, code;
    if ({a, s, d} != m_prev && len >= 16) begin
      sl = ref_slot(a);
      if (sl >= 0) begin
        code = ref_decode(s);
        m_sh[sl] = code; m_sdp[sl] = ~d; m_seen[sl] = 1'b1; m_off = 1'b0;
        if (code == 14) begin m_es++; if (m_ec < 255) m_ec++; end
        if (m_seen == 4'hF) begin
          for (int i = 0; i < 4; i++) m_dig[i] = m_sh[i];
          m_dpm = m_sdp; m_fv++; m_seen = 0;
        end
      end else if (a == 4'hF) begin
        m_off = 1'b1; m_seen = 0;
      end else begin
        m_ea++; if (m_ec < 255) m_ec++;
      end
    end
    m_prev = {a, s, d};
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          len;
    logic [15:0] dig;
    logic [3:0]  dpm;
    logic        off;
    int          fv;
    int          ea;
    int          es;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int lat, bfv, bea, bes;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    int         len, r;

    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

    tbl[0]  = '{4'b0111, 7'h79, 1'b1, 20, 16'hFFFF, 4'h0, 1'b0, 0, 0, 0};
    tbl[1]  = '{4'b1011, 7'h24, 1'b0, 20, 16'hFFFF, 4'h0, 1'b0, 0, 0, 0};
    tbl[2]  = '{4'b1101, 7'h30, 1'b1, 20, 16'hFFFF, 4'h0, 1'b0, 0, 0, 0};
    tbl[3]  = '{4'b1110, 7'h19, 1'b1, 20, 16'h4321, 4'h2, 1'b0, 1, 0, 0};
    tbl[4]  = '{4'b0111, 7'h40, 1'b1,  5, 16'h4321, 4'h2, 1'b0, 1, 0, 0};
    tbl[5]  = '{4'b0111, 7'h79, 1'b1,  5, 16'h4321, 4'h2, 1'b0, 1, 0, 0};
    tbl[6]  = '{4'b0111, 7'h40, 1'b1,  5, 16'h4321, 4'h2, 1'b0, 1, 0, 0};
    tbl[7]  = '{4'b0111, 7'h79, 1'b1,  5, 16'h4321, 4'h2, 1'b0, 1, 0, 0};
    tbl[8]  = '{4'b1011, 7'h40, 1'b1, 20, 16'h4321, 4'h2, 1'b0, 1, 0, 0};
    tbl[9]  = '{4'b1101, 7'h09, 1'b1, 20, 16'h4321, 4'h2, 1'b0, 1, 0, 1};
    tbl[10] = '{4'b1110, 7'h02, 1'b1, 20, 16'h4321, 4'h2, 1'b0, 1, 0, 1};
    tbl[11] = '{4'b0111, 7'h12, 1'b0, 20, 16'h6E05, 4'h1, 1'b0, 2, 0, 1};
    tbl[12] = '{4'b0111, 7'h79, 1'b1, 20, 16'h6E05, 4'h1, 1'b0, 2, 0, 1};
    tbl[13] = '{4'b0011, 7'h79, 1'b1, 20, 16'h6E05, 4'h1, 1'b0, 2, 1, 1};
    tbl[14] = '{4'b1111, 7'h7F, 1'b1, 20, 16'h6E05, 4'h1, 1'b1, 2, 1, 1};
    tbl[15] = '{4'b1011, 7'h79, 1'b1, 20, 16'h6E05, 4'h1, 1'b0, 2, 1, 1};
    tbl[16] = '{4'b1101, 7'h24, 1'b1, 20, 16'h6E05, 4'h1, 1'b0, 2, 1, 1};
    tbl[17] = '{4'b1110, 7'h30, 1'b1, 20, 16'h6E05, 4'h1, 1'b0, 2, 1, 1};
    tbl[18] = '{4'b0111, 7'h19, 1'b1, 20, 16'h3214, 4'h0, 1'b0, 3, 1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", dig_word(), 16'hFFFF);
    chk("reset_dp_mask", int'(dp_mask), 0);
    chk("reset_flags", int'({frame_valid, display_off, err_anode, err_seg}), 0);
`ifdef SEVENSEG_DEC_ERRCNT_EN
    chk("reset_err_count", int'(err_count), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      hold(tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].len);
      chk($sformatf("tbl%0d_digits", i), dig_word(), int'(tbl[i].dig));
      chk($sformatf("tbl%0d_dp_mask", i), int'(dp_mask), int'(tbl[i].dpm));
      chk($sformatf("tbl%0d_display_off", i), int'(display_off), int'(tbl[i].off));
      chk($sformatf("tbl%0d_frames", i), fv_cnt, tbl[i].fv);
      chk($sformatf("tbl%0d_err_anode", i), ea_cnt, tbl[i].ea);
      chk($sformatf("tbl%0d_err_seg", i), es_cnt, tbl[i].es);
`ifdef SEVENSEG_DEC_ERRCNT_EN
      chk($sformatf("tbl%0d_err_count", i), int'(err_count), tbl[i].ea + tbl[i].es);
`endif
    end

    // Pin change to frame_valid latency: 2 sync + 16 stable + 1 register
    hold(4'b0111, 7'h78, 1'b1, 20);
    hold(4'b1011, 7'h10, 1'b1, 20);
    hold(4'b1101, 7'h00, 1'b0, 20);
    an = 4'b1110; seg = 7'h40; dp = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin lat = k; break; end
    end
    chk("frame_latency", lat, 19);
    hold(4'b1110, 7'h40, 1'b1, 5);
    chk("lat_digits", dig_word(), 16'h0897);
    chk("lat_dp_mask", int'(dp_mask), 4'b0100);
    chk("lat_frames", fv_cnt, 4);

    // Reset after three of four slots
    hold(4'b0111, 7'h79, 1'b1, 20);
    hold(4'b1011, 7'h24, 1'b0, 20);
    hold(4'b1101, 7'h30, 1'b1, 20);
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", dig_word(), 16'hFFFF);
    chk("midrst_dp_mask", int'(dp_mask), 0);
    chk("midrst_flags", int'({frame_valid, display_off, err_anode, err_seg}), 0);
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(4'b1110, 7'h19, 1'b1, 30);
    chk("postrst_no_frame", fv_cnt, 4);
    chk("postrst_digits", dig_word(), 16'hFFFF);

    // Randomized scans against the segment-level model
    do_reset();
    model_reset();
    bfv = fv_cnt; bea = ea_cnt; bes = es_cnt;
    for (int n = 0; n < 60; n++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 7) a = ~(4'b1000 >> $urandom_range(0, 3));
        else if (r == 7) a = 4'hF;
        else begin
          do a = 4'($urandom); while ($countones(a) == 3 || a == 4'hF);
        end
        if (a == 4'hF) s = 7'h7F;
        else if ($urandom_range(0, 4) != 0) s = pat[$urandom_range(0, 10)];
        else s = 7'($urandom);
        d = 1'($urandom);
      end while ({a, s, d} == m_prev);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 12)) : int'($urandom_range(20, 28));
      model_segment(a, s, d, len);
      hold(a, s, d, len);
      chk($sformatf("rnd%0d_digits", n), dig_word(), (m_dig[3] << 12) | (m_dig[2] << 8) | (m_dig[1] << 4) | m_dig[0]);
      chk($sformatf("rnd%0d_dp_mask", n), int'(dp_mask), int'(m_dpm));
      chk($sformatf("rnd%0d_display_off", n), int'(display_off), int'(m_off));
      chk($sformatf("rnd%0d_frames", n), fv_cnt - bfv, m_fv);
      chk($sformatf("rnd%0d_err_anode", n), ea_cnt - bea, m_ea);
      chk($sformatf("rnd%0d_err_seg", n), es_cnt - bes, m_es);
`ifdef SEVENSEG_DEC_ERRCNT_EN
      chk($sformatf("rnd%0d_err_count", n), int'(err_count), m_ec);
`endif
    end

`ifdef SEVENSEG_DEC_ERRCNT_EN
    do_reset();
    bes = es_cnt;
    for (int i = 0; i < 300; i++)
      hold(4'b1101, (i % 2 == 1) ? 7'h0B : 7'h09, 1'b1, 18);
    chk("errcnt_events", es_cnt - bes, 300);
    chk("errcnt_saturated", int'(err_count), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
